keycard_spi_sequencer: RTL and testbench

KEYCARD_SPI_SEQUENCER -- requirements
Module: keycard_spi_sequencer

---
 rtl/keycard_spi_sequencer.sv | 157 +++++++++++++++
 tb/tb_keycard_spi_sequencer.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keycard_spi_sequencer.sv
// keycard_spi_sequencer
// Frames one keycard instruction over a byte-wide SPI master link:
// 1 command byte, FRAME_DATA_BYTES payload bytes, then FRAME_DATA_BYTES
// 0x00 filler bytes. The reply to the filler bytes becomes o_Resp.
// Build option: define KEYCARD_SEQ_TIMEOUT_EN to add a watchdog that aborts
// a stalled frame with o_Err=2.
//
// Handshake: o_TX_DV pulses for one cycle with o_TX_Byte when i_TX_Ready was
// high and no byte is outstanding; that byte stays outstanding until the SPI
// master returns i_RX_DV. i_RX_DV with nothing outstanding is ignored.
// o_Dbg_State exposes the FSM state for checkers.
module keycard_spi_sequencer #(
   parameter int TIMEOUT_CLKS     = 4096,
   parameter int FRAME_DATA_BYTES = 16
) (
   input  logic         i_Clk,
   input  logic         i_Rst,
   input  logic         i_Cmd_Valid,
   input  logic [7:0]   i_Cmd,
   input  logic [127:0] i_Payload,
   output logic         o_Busy,
   output logic         o_Done,
   output logic [1:0]   o_Err,
   output logic [127:0] o_Resp,
   output logic [7:0]   o_TX_Byte,
   output logic         o_TX_DV,
   input  logic         i_TX_Ready,
   input  logic         i_RX_DV,
   input  logic [7:0]   i_RX_Byte,
   output logic [2:0]   o_Dbg_State
);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_SEND_CMD  = 3'd1,
      S_SEND_DATA = 3'd2,
      S_RECV      = 3'd3,
      S_DONE      = 3'd4
   } state_t;

   localparam logic [5:0] LAST_DATA = 6'(FRAME_DATA_BYTES);
   localparam logic [5:0] LAST_BYTE = 6'(2 * FRAME_DATA_BYTES);

   state_t         state_q, state_d;
   logic [5:0]     cnt_q;
   logic           pend_q;
   logic [7:0]     cmd_q;
   logic [127:0]   payload_q;
   logic [1:0]     err_q;

   logic           cmd_legal, accept, active, active_d, rx_ok, issue, timeout_hit;
   logic           tx_dv_d, busy_d, done_d;
   logic [7:0]     tx_byte_d;
   logic [1:0]     err_out_d;

   assign cmd_legal   = (i_Cmd == 8'h10) || (i_Cmd == 8'h11) || (i_Cmd == 8'h12);
   assign accept      = (state_q == S_IDLE) && i_Cmd_Valid && !o_Busy;
   assign active      = (state_q == S_SEND_CMD) || (state_q == S_SEND_DATA) || (state_q == S_RECV);
   assign active_d    = (state_d == S_SEND_CMD) || (state_d == S_SEND_DATA) || (state_d == S_RECV);
   assign rx_ok       = active && pend_q && i_RX_DV;
   assign issue       = active && i_TX_Ready && !pend_q && !timeout_hit;
   assign o_Dbg_State = state_q;

`ifdef KEYCARD_SEQ_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CLKS + 1);
   // The abort passes through the DONE state and the registered o_Done, and the
   // byte issued right after an i_RX_DV is not a counting cycle, so firing at
   // TIMEOUT_CLKS-4 puts o_Done exactly TIMEOUT_CLKS clocks after that i_RX_DV.
   localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CLKS - 4);
   logic [WD_W-1:0] wd_q;

   assign timeout_hit = active && (wd_q == WD_LIMIT);

   // Watchdog: restarts on acceptance and each returned byte, counts stalls.
   always_ff @(posedge i_Clk) begin
      if (i_Rst || accept || rx_ok)
         wd_q <= '0;
      else if (active && (pend_q || !i_TX_Ready))
         wd_q <= wd_q + 1'b1;
   end
`else
   assign timeout_hit = 1'b0;
`endif

   // State register.
   always_ff @(posedge i_Clk) begin
      if (i_Rst) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // Next-state: byte counter value is the index of the outstanding byte.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:      if (accept) state_d = cmd_legal ? S_SEND_CMD : S_DONE;
         S_SEND_CMD:  if (timeout_hit) state_d = S_DONE;
                      else if (rx_ok) state_d = S_SEND_DATA;
         S_SEND_DATA: if (timeout_hit) state_d = S_DONE;
                      else if (rx_ok && (cnt_q == LAST_DATA)) state_d = S_RECV;
         S_RECV:      if (timeout_hit) state_d = S_DONE;
                      else if (rx_ok && (cnt_q == LAST_BYTE)) state_d = S_DONE;
         S_DONE:      state_d = S_IDLE;
         default:     state_d = S_IDLE;
      endcase
   end

   // Output values for the next cycle, derived from the current state.
   always_comb begin
      tx_dv_d   = issue;
      tx_byte_d = 8'h00;
      case (state_q)
         S_SEND_CMD:  tx_byte_d = cmd_q;
         S_SEND_DATA: tx_byte_d = payload_q[127:120];
         default:     tx_byte_d = 8'h00;
      endcase
      busy_d    = (state_d != S_IDLE) || (state_q == S_DONE);
      done_d    = (state_q == S_DONE);
      err_out_d = done_d ? err_q : 2'd0;
   end

   // Registered outputs and frame datapath.
   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         o_Busy    <= 1'b0;
         o_Done    <= 1'b0;
         o_Err     <= 2'd0;
         o_Resp    <= '0;
         o_TX_Byte <= 8'h00;
         o_TX_DV   <= 1'b0;
         cnt_q     <= 6'd0;
         pend_q    <= 1'b0;
         cmd_q     <= 8'h00;
         payload_q <= '0;
         err_q     <= 2'd0;
      end else begin
         o_TX_DV <= tx_dv_d;
         o_Busy  <= busy_d;
         o_Done  <= done_d;
         o_Err   <= err_out_d;
         if (issue) o_TX_Byte <= tx_byte_d;
         if (accept) begin
            cmd_q     <= i_Cmd;
            payload_q <= (i_Cmd == 8'h11) ? i_Payload : '0;
            cnt_q     <= 6'd0;
            err_q     <= cmd_legal ? 2'd0 : 2'd1;
         end
         if (issue && (state_q == S_SEND_DATA)) payload_q <= {payload_q[119:0], 8'h00};
         if (rx_ok) begin
            cnt_q <= cnt_q + 6'd1;
            if (state_q == S_RECV) o_Resp <= {o_Resp[119:0], i_RX_Byte};
         end
         if (timeout_hit) err_q <= 2'd2;
         pend_q <= active_d && (issue || (pend_q && !rx_ok));
      end
   end

endmodule

// File: tb/tb_keycard_spi_sequencer.sv
// tb_keycard_spi_sequencer
// Directed vector table of whole frames against a behavioural SPI master that
// echoes rx_base+n for byte n, plus hand-written multi-cycle corner cases.
// Honours KEYCARD_SEQ_TIMEOUT_EN the same way the design does.
module tb_keycard_spi_sequencer;

   logic         i_Clk = 1'b0;
   logic         i_Rst = 1'b1;
   logic         i_Cmd_Valid = 1'b0;
   logic [7:0]   i_Cmd = 8'h00;
   logic [127:0] i_Payload = '0;
   logic         o_Busy, o_Done, o_TX_DV;
   logic [1:0]   o_Err;
   logic [127:0] o_Resp;
   logic [7:0]   o_TX_Byte;
   logic         i_TX_Ready = 1'b1;
   logic         i_RX_DV = 1'b0;
   logic [7:0]   i_RX_Byte = 8'h00;
   logic [2:0]   o_Dbg_State;

   keycard_spi_sequencer #(.TIMEOUT_CLKS(64), .FRAME_DATA_BYTES(16)) dut (
      .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Cmd_Valid(i_Cmd_Valid), .i_Cmd(i_Cmd),
      .i_Payload(i_Payload), .o_Busy(o_Busy), .o_Done(o_Done), .o_Err(o_Err),
      .o_Resp(o_Resp), .o_TX_Byte(o_TX_Byte), .o_TX_DV(o_TX_DV),
      .i_TX_Ready(i_TX_Ready), .i_RX_DV(i_RX_DV), .i_RX_Byte(i_RX_Byte),
      .o_Dbg_State(o_Dbg_State)
   );

   // Clock / reset
   always #5 i_Clk = ~i_Clk;

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   // Controls written only by the test process
   int          frame_id = 0;
   logic [7:0]  rx_base = 8'hA0;
   int          rx_lat = 0;
   int          withhold_from = 1000;
   bit          rdy_mode = 1'b0;

   // Observations written only by the SPI master model
   int          seen_id = 0;
   int          cyc = 0;
   int          byte_idx = 0;
   int          tx_pulses = 0;
   int          done_cnt = 0;
   int          viol = 0;
   int          last_rx_cyc = 0;
   int          done_cyc = 0;
   logic [1:0]  done_err = 2'd0;
   logic [127:0] done_resp = '0;
   logic [7:0]  tx_log[$];

   // Scoreboard
   logic [7:0]  exp_q[$];
   int          errors = 0;
   int          checks = 0;

   // SPI master model: logs bytes, answers each after rx_lat idle cycles.
   initial begin
      bit pend;
      int wcnt;
      int cur_n;
      pend = 1'b0; wcnt = 0; cur_n = 0;
      forever begin
         @(posedge i_Clk); #1;
         cyc++;
         if (frame_id != seen_id) begin
            seen_id = frame_id;
            byte_idx = 0; tx_pulses = 0; done_cnt = 0; pend = 1'b0;
            tx_log.delete();
         end
         i_RX_DV = 1'b0;
         if (o_Done) begin
            done_cnt++; done_err = o_Err; done_resp = o_Resp; done_cyc = cyc;
         end
         if (o_TX_DV) begin
            if (!i_TX_Ready || pend) viol++;
            tx_pulses++;
            tx_log.push_back(o_TX_Byte);
            pend = 1'b1; wcnt = rx_lat; cur_n = byte_idx; byte_idx++;
         end else if (pend) begin
            if (wcnt > 0) wcnt--;
            else if (cur_n < withhold_from) begin
               i_RX_DV = 1'b1; i_RX_Byte = rx_base + 8'(cur_n);
               pend = 1'b0; last_rx_cyc = cyc;
            end
         end
         i_TX_Ready = rdy_mode ? ((cyc % 3) != 0) : 1'b1;
      end
   end

   // Driver tasks
   task automatic step();
      @(posedge i_Clk); #1;
   endtask

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic start_frame(input logic [7:0] cmd, input logic [127:0] pl);
      frame_id++;
      step(); step();
      i_Cmd = cmd; i_Payload = pl; i_Cmd_Valid = 1'b1;
      step();
      i_Cmd_Valid = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int k;
      k = 0;
      while (done_cnt == 0 && k < 3000) begin step(); k++; end
      check(name, 128'(done_cnt != 0), 128'd1);
   endtask

   task automatic wait_bytes(input int n, input string name);
      int k;
      k = 0;
      while (byte_idx < n && k < 3000) begin step(); k++; end
      check(name, 128'(byte_idx >= n), 128'd1);
   endtask

   function automatic logic [7:0] exp_tx(input logic [7:0] cmd, input logic [127:0] pl, input int i);
      logic [127:0] t;
      t = pl;
      if (i == 0) return cmd;
      if (i <= 16) return (cmd == 8'h11) ? t[127 - 8*(i-1) -: 8] : 8'h00;
      return 8'h00;
   endfunction

   function automatic logic [127:0] resp_of(input logic [7:0] base);
      logic [127:0] r;
      r = '0;
      for (int j = 0; j < 16; j++) r[127 - 8*j -: 8] = base + 8'(17 + j);
      return r;
   endfunction

   task automatic check_tx_log(input string name, input logic [7:0] cmd, input logic [127:0] pl, input int n);
      logic [7:0] act;
      exp_q.delete();
      for (int i = 0; i < n; i++) exp_q.push_back(exp_tx(cmd, pl, i));
      for (int i = 0; i < n; i++) begin
         act = (i < tx_log.size()) ? tx_log[i] : 8'hxx;
         check($sformatf("%s_byte%0d", name, i), 128'(act), 128'(exp_q.pop_front()));
      end
   endtask

   typedef struct {
      logic [7:0]   cmd;
      logic [127:0] payload;
      logic [7:0]   base;
      bit           rdy_toggle;
      int           lat;
      int           exp_pulses;
      logic [1:0]   exp_err;
   } vec_t;

   vec_t vt[8];
   logic [127:0] cur_resp;

   initial begin
      vt[0] = '{8'h10, 128'h0, 8'hA0, 1'b0, 0, 33, 2'd0};
      vt[1] = '{8'h11, 128'h00112233445566778899AABBCCDDEEFF, 8'h30, 1'b1, 2, 33, 2'd0};
      vt[2] = '{8'h12, 128'hDEADBEEF0123456789ABCDEFFEDCBA98, 8'h55, 1'b0, 1, 33, 2'd0};
      vt[3] = '{8'h7F, 128'h0, 8'h00, 1'b0, 0, 0, 2'd1};
      vt[4] = '{8'h00, 128'h0, 8'h00, 1'b0, 0, 0, 2'd1};
      vt[5] = '{8'h13, 128'h0, 8'h00, 1'b0, 0, 0, 2'd1};
      vt[6] = '{8'h11, {128{1'b1}}, 8'hF0, 1'b1, 0, 33, 2'd0};
      vt[7] = '{8'h0F, 128'h5, 8'h00, 1'b0, 0, 0, 2'd1};
      cur_resp = '0;

      // Reset state
      i_Rst = 1'b1;
      repeat (3) step();
      i_Rst = 1'b0;
      check("rst_busy", 128'(o_Busy), 128'd0);
      check("rst_done", 128'(o_Done), 128'd0);
      check("rst_err", 128'(o_Err), 128'd0);
      check("rst_tx_dv", 128'(o_TX_DV), 128'd0);
      check("rst_tx_byte", 128'(o_TX_Byte), 128'd0);
      check("rst_resp", o_Resp, 128'd0);
      check("rst_state", 128'(o_Dbg_State), 128'd0);

      // Table-driven frames
      for (int v = 0; v < 8; v++) begin
         rx_base = vt[v].base; rx_lat = vt[v].lat; rdy_mode = vt[v].rdy_toggle;
         start_frame(vt[v].cmd, vt[v].payload);
         wait_done($sformatf("v%0d_done_seen", v));
         repeat (4) step();
         if (vt[v].exp_err == 2'd0) cur_resp = resp_of(vt[v].base);
         check($sformatf("v%0d_pulses", v), 128'(tx_pulses), 128'(vt[v].exp_pulses));
         check($sformatf("v%0d_done_cnt", v), 128'(done_cnt), 128'd1);
         check($sformatf("v%0d_err", v), 128'(done_err), 128'(vt[v].exp_err));
         check($sformatf("v%0d_resp", v), done_resp, cur_resp);
         check($sformatf("v%0d_busy_after", v), 128'(o_Busy), 128'd0);
         check_tx_log($sformatf("v%0d", v), vt[v].cmd, vt[v].payload, vt[v].exp_pulses);
      end
      rdy_mode = 1'b0; rx_lat = 0;

      // Illegal command: o_Done on the 2nd cycle after the strobe
      start_frame(8'h7F, 128'h0);
      check("ill_c1_done", 128'(o_Done), 128'd0);
      check("ill_c1_busy", 128'(o_Busy), 128'd1);
      step();
      check("ill_c2_done", 128'(o_Done), 128'd1);
      check("ill_c2_err", 128'(o_Err), 128'd1);
      step();
      check("ill_c3_done", 128'(o_Done), 128'd0);
      check("ill_c3_busy", 128'(o_Busy), 128'd0);
      check("ill_no_tx", 128'(tx_pulses), 128'd0);

      // Accept-to-first-TX latency with ready high
      rx_base = 8'h60;
      start_frame(8'h12, 128'h0);
      check("lat_c1_tx_dv", 128'(o_TX_DV), 128'd0);
      check("lat_c1_busy", 128'(o_Busy), 128'd1);
      step();
      check("lat_c2_tx_dv", 128'(o_TX_DV), 128'd1);
      check("lat_c2_tx_byte", 128'(o_TX_Byte), 128'h12);
      wait_done("lat_done_seen");
      repeat (4) step();
      cur_resp = resp_of(8'h60);
      check("lat_resp", done_resp, cur_resp);

      // Re-strobe mid-frame is ignored; inputs are latched at acceptance
      rx_base = 8'h10;
      start_frame(8'h11, 128'h0102030405060708090A0B0C0D0E0F10);
      wait_bytes(5, "restrobe_reach_byte5");
      i_Cmd = 8'h10; i_Payload = ~128'h0102030405060708090A0B0C0D0E0F10; i_Cmd_Valid = 1'b1;
      step();
      i_Cmd_Valid = 1'b0;
      wait_done("restrobe_done_seen");
      repeat (40) step();
      cur_resp = resp_of(8'h10);
      check("restrobe_pulses", 128'(tx_pulses), 128'd33);
      check("restrobe_done_cnt", 128'(done_cnt), 128'd1);
      check("restrobe_err", 128'(done_err), 128'd0);
      check("restrobe_resp", done_resp, cur_resp);
      check_tx_log("restrobe", 8'h11, 128'h0102030405060708090A0B0C0D0E0F10, 33);

      // Reset at byte 20 with the reply still in flight
      rx_lat = 4; rx_base = 8'hC0;
      start_frame(8'h10, 128'h0);
      wait_bytes(21, "rstmid_reach_byte20");
      i_Rst = 1'b1;
      step();
      i_Rst = 1'b0;
      check("rstmid_busy", 128'(o_Busy), 128'd0);
      check("rstmid_done", 128'(o_Done), 128'd0);
      check("rstmid_tx_dv", 128'(o_TX_DV), 128'd0);
      check("rstmid_tx_byte", 128'(o_TX_Byte), 128'd0);
      check("rstmid_err", 128'(o_Err), 128'd0);
      check("rstmid_resp", o_Resp, 128'd0);
      check("rstmid_state", 128'(o_Dbg_State), 128'd0);
      repeat (20) step();
      check("rstmid_no_done", 128'(done_cnt), 128'd0);
      check("rstmid_no_more_tx", 128'(tx_pulses), 128'd21);
      check("rstmid_idle_busy", 128'(o_Busy), 128'd0);
      cur_resp = '0;
      rx_lat = 0; rx_base = 8'h44;
      start_frame(8'h12, 128'hFFFF);
      wait_done("rstmid_new_done_seen");
      repeat (4) step();
      cur_resp = resp_of(8'h44);
      check("rstmid_new_pulses", 128'(tx_pulses), 128'd33);
      check("rstmid_new_err", 128'(done_err), 128'd0);
      check("rstmid_new_resp", done_resp, cur_resp);
      check_tx_log("rstmid_new", 8'h12, 128'hFFFF, 33);

      // Stalled frame: replies withheld after byte 3
      withhold_from = 4; rx_base = 8'h20;
      start_frame(8'h10, 128'h0);
`ifdef KEYCARD_SEQ_TIMEOUT_EN
      wait_done("to_done_seen");
      repeat (4) step();
      check("to_err", 128'(done_err), 128'd2);
      check("to_latency", 128'(done_cyc - last_rx_cyc), 128'd64);
      check("to_resp_held", done_resp, cur_resp);
      check("to_pulses", 128'(tx_pulses), 128'd5);
      check("to_done_cnt", 128'(done_cnt), 128'd1);
`else
      repeat (300) step();
      check("stall_no_done", 128'(done_cnt), 128'd0);
      check("stall_busy", 128'(o_Busy), 128'd1);
      check("stall_pulses", 128'(tx_pulses), 128'd5);
      i_Rst = 1'b1;
      step();
      i_Rst = 1'b0;
      check("stall_rst_busy", 128'(o_Busy), 128'd0);
`endif
      withhold_from = 1000;
      repeat (4) step();

      check("protocol_viol", 128'(viol), 128'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
